// File: rtl/life_step_engine.sv
// Double-buffered Game of Life grid engine: one generation per step request, one row per clock.
// Build with LIFE_TORUS_EN defined to make the grid wrap toroidally; otherwise the edges are fixed-dead.
module life_step_engine #(
    parameter int COLS     = 32,
    parameter int ROWS     = 32,
    parameter int RW       = $clog2(ROWS),
    parameter int CW       = $clog2(COLS),
    parameter int STEP_DIV = 25_000_000
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iRun,
    input  logic            iStep,
    input  logic            iToggle,
    input  logic [CW-1:0]   iCellX,
    input  logic [RW-1:0]   iCellY,
    input  logic [RW-1:0]   iRdRow,
    output logic [COLS-1:0] oRdData,
    output logic            oBusy,
    output logic [15:0]     oGen
);

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [DW-1:0]   DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]   DIV_ZERO = {DW{1'b0}};
    localparam logic [RW-1:0]   ROW_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0]   ROW_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0]   ROW_TWO  = {{(RW-2){1'b0}}, 2'b10};
    localparam logic [RW-1:0]   ROW_LAST = {RW{1'b1}};
    localparam logic [COLS-1:0] ZERO_ROW = {COLS{1'b0}};
    localparam logic [COLS-1:0] SEED_R0  = {{(COLS-3){1'b0}}, 3'b010};
    localparam logic [COLS-1:0] SEED_R1  = {{(COLS-3){1'b0}}, 3'b100};
    localparam logic [COLS-1:0] SEED_R2  = {{(COLS-3){1'b0}}, 3'b111};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_SWAP    = 2'd2
    } state_t;

    state_t            r_state;
    logic [COLS-1:0]   r_bank_a [ROWS];
    logic [COLS-1:0]   r_bank_b [ROWS];
    logic              r_front;
    logic [RW-1:0]     r_row;
    logic              r_pending;
    logic [DW-1:0]     r_div;
    logic              r_busy;
    logic [15:0]       r_gen;
    logic [COLS-1:0]   r_rd_data;

    logic              w_tick;
    logic              w_req;
    logic [RW-1:0]     w_row_up;
    logic [RW-1:0]     w_row_dn;
    logic [COLS-1:0]   w_up_raw;
    logic [COLS-1:0]   w_dn_raw;
    logic [COLS-1:0]   w_up;
    logic [COLS-1:0]   w_mid;
    logic [COLS-1:0]   w_dn;
    logic [COLS-1:0]   w_rd;
    logic [COLS-1:0]   w_next;

    // Bit x of the result holds v[x-1] (left neighbour column).
    function automatic logic [COLS-1:0] from_left(input logic [COLS-1:0] v);
`ifdef LIFE_TORUS_EN
        return {v[COLS-2:0], v[COLS-1]};
`else
        return {v[COLS-2:0], 1'b0};
`endif
    endfunction

    // Bit x of the result holds v[x+1] (right neighbour column).
    function automatic logic [COLS-1:0] from_right(input logic [COLS-1:0] v);
`ifdef LIFE_TORUS_EN
        return {v[0], v[COLS-1:1]};
`else
        return {1'b0, v[COLS-1:1]};
`endif
    endfunction

    function automatic logic [COLS-1:0] next_row(input logic [COLS-1:0] up,
                                                 input logic [COLS-1:0] mid,
                                                 input logic [COLS-1:0] dn);
        logic [COLS-1:0] ul, ur, ml, mr, dl, dr, res;
        logic [3:0]      cnt;
        ul = from_left(up);  ur = from_right(up);
        ml = from_left(mid); mr = from_right(mid);
        dl = from_left(dn);  dr = from_right(dn);
        res = ZERO_ROW;
        for (int x = 0; x < COLS; x++) begin
            cnt = {3'd0, ul[x]} + {3'd0, up[x]} + {3'd0, ur[x]} + {3'd0, ml[x]}
                + {3'd0, mr[x]} + {3'd0, dl[x]} + {3'd0, dn[x]} + {3'd0, dr[x]};
            res[x] = (cnt == 4'd3) || (mid[x] && (cnt == 4'd2));
        end
        return res;
    endfunction

    assign w_tick   = iRun && (r_div == DIV_LAST);
    assign w_req    = r_pending | iStep | w_tick;
    assign w_row_up = r_row - ROW_ONE;
    assign w_row_dn = r_row + ROW_ONE;

    // Front-bank row fetches for the neighbour window and the renderer port.
    always_comb begin
        w_up_raw = ZERO_ROW;
        w_mid    = ZERO_ROW;
        w_dn_raw = ZERO_ROW;
        w_rd     = ZERO_ROW;
        if (r_front) begin
            w_up_raw = r_bank_b[w_row_up];
            w_mid    = r_bank_b[r_row];
            w_dn_raw = r_bank_b[w_row_dn];
            w_rd     = r_bank_b[iRdRow];
        end else begin
            w_up_raw = r_bank_a[w_row_up];
            w_mid    = r_bank_a[r_row];
            w_dn_raw = r_bank_a[w_row_dn];
            w_rd     = r_bank_a[iRdRow];
        end
    end

    // Row index arithmetic wraps naturally, so only the fixed-dead build masks the edges.
`ifdef LIFE_TORUS_EN
    assign w_up = w_up_raw;
    assign w_dn = w_dn_raw;
`else
    assign w_up = (r_row == ROW_ZERO) ? ZERO_ROW : w_up_raw;
    assign w_dn = (r_row == ROW_LAST) ? ZERO_ROW : w_dn_raw;
`endif

    assign w_next = next_row(w_up, w_mid, w_dn);

    // Control FSM, grid storage, request capture, divider and registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= S_IDLE;
            r_front   <= 1'b0;
            r_row     <= ROW_ZERO;
            r_pending <= 1'b0;
            r_div     <= DIV_ZERO;
            r_busy    <= 1'b0;
            r_gen     <= 16'd0;
            r_rd_data <= ZERO_ROW;
            for (int r = 0; r < ROWS; r++) begin
                r_bank_a[r] <= ZERO_ROW;
                r_bank_b[r] <= ZERO_ROW;
            end
            r_bank_a[ROW_ZERO] <= SEED_R0;
            r_bank_a[ROW_ONE]  <= SEED_R1;
            r_bank_a[ROW_TWO]  <= SEED_R2;
        end else begin
            if (!iRun) begin
                r_div <= DIV_ZERO;
            end else if (r_div == DIV_LAST) begin
                r_div <= DIV_ZERO;
            end else begin
                r_div <= r_div + DIV_ONE;
            end

            r_rd_data <= w_rd;

            case (r_state)
                S_IDLE: begin
                    // Edits land on the front bank at the same edge a step is accepted.
                    if (iToggle) begin
                        if (r_front) begin
                            r_bank_b[iCellY][iCellX] <= ~r_bank_b[iCellY][iCellX];
                        end else begin
                            r_bank_a[iCellY][iCellX] <= ~r_bank_a[iCellY][iCellX];
                        end
                    end
                    r_pending <= 1'b0;
                    if (w_req) begin
                        r_state <= S_COMPUTE;
                        r_row   <= ROW_ZERO;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    r_pending <= w_req;
                    r_busy    <= 1'b1;
                    if (r_front) begin
                        r_bank_a[r_row] <= w_next;
                    end else begin
                        r_bank_b[r_row] <= w_next;
                    end
                    r_row <= r_row + ROW_ONE;
                    if (r_row == ROW_LAST) begin
                        r_state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    r_pending <= w_req;
                    r_front   <= ~r_front;
                    r_gen     <= r_gen + 16'd1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_pending <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign oRdData = r_rd_data;
    assign oBusy   = r_busy;
    assign oGen    = r_gen;

endmodule

// File: tb/tb_life_step_engine.sv
// Self-checking bench for life_step_engine against a cell-by-cell Game of Life model.
module tb_life_step_engine;

    localparam int COLS     = 32;
    localparam int ROWS     = 32;
    localparam int RW       = 5;
    localparam int CW       = 5;
    localparam int STEP_DIV = 40;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            run = 1'b0;
    logic            step = 1'b0;
    logic            tog = 1'b0;
    logic [CW-1:0]   cx = '0;
    logic [RW-1:0]   cy = '0;
    logic [RW-1:0]   rdrow = '0;
    logic [COLS-1:0] rd;
    logic            busy;
    logic [15:0]     gen;

    int errors = 0;
    int checks = 0;
    logic [COLS-1:0] m_grid [ROWS];
    logic [COLS-1:0] dut_grid [ROWS];
    int m_gen = 0;

    always #5 clk = ~clk;

    life_step_engine #(
        .COLS(COLS), .ROWS(ROWS), .RW(RW), .CW(CW), .STEP_DIV(STEP_DIV)
    ) dut (
        .iCLK(clk), .iRST(rst), .iRun(run), .iStep(step), .iToggle(tog),
        .iCellX(cx), .iCellY(cy), .iRdRow(rdrow),
        .oRdData(rd), .oBusy(busy), .oGen(gen)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_cell(input int y, input int x);
`ifdef LIFE_TORUS_EN
        y = (y + ROWS) % ROWS;
        x = (x + COLS) % COLS;
`else
        if (y < 0 || y >= ROWS || x < 0 || x >= COLS) return 1'b0;
`endif
        return m_grid[y][x];
    endfunction

    task automatic model_seed;
        for (int r = 0; r < ROWS; r++) m_grid[r] = '0;
        m_grid[0] = 32'h2;
        m_grid[1] = 32'h4;
        m_grid[2] = 32'h7;
        m_gen = 0;
    endtask

    task automatic model_step;
        logic [COLS-1:0] nxt [ROWS];
        int n;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0) n += int'(m_cell(y + dy, x + dx));
                nxt[y][x] = (n == 3) || (m_grid[y][x] && n == 2);
            end
        end
        for (int y = 0; y < ROWS; y++) m_grid[y] = nxt[y];
        m_gen = (m_gen + 1) % 65536;
    endtask

    task automatic read_grid;
        for (int r = 0; r < ROWS; r++) begin
            rdrow = r[RW-1:0];
            tick();
            dut_grid[r] = rd;
        end
    endtask

    task automatic do_reset;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        model_seed();
    endtask

    task automatic do_toggle(input int x, input int y);
        cx = x[CW-1:0];
        cy = y[RW-1:0];
        tog = 1'b1;
        tick();
        tog = 1'b0;
        m_grid[y][x] = ~m_grid[y][x];
    endtask

    task automatic clear_grid;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (m_grid[y][x]) do_toggle(x, y);
    endtask

    task automatic run_step(output int nbusy);
        step = 1'b1;
        tick();
        step = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 200) begin
            nbusy++;
            tick();
        end
        model_step();
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #2;
        checks++; if (gen !== 16'd0) begin errors++; $display("FAIL reset_gen: got %0d expected 0", gen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h expected 0", rd); end
        tick();
        rst = 1'b0;
        model_seed();
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL reset_seed row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
    endtask

    task automatic test_blinker;
        int nb;
        do_reset();
        clear_grid();
        do_toggle(5, 10); do_toggle(6, 10); do_toggle(7, 10);
        run_step(nb);
        checks++; if (nb != 33) begin errors++; $display("FAIL blinker_busy: got %0d cycles expected 33", nb); end
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL blinker_gen1 row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
        for (int r = 9; r <= 11; r++) begin
            checks++;
            if (dut_grid[r] !== 32'h40) begin
                errors++; $display("FAIL blinker_vertical row %0d: got %h expected 00000040", r, dut_grid[r]);
            end
        end
        checks++; if (gen !== 16'd1) begin errors++; $display("FAIL blinker_gen: got %0d expected 1", gen); end
        run_step(nb);
        read_grid();
        checks++; if (dut_grid[10] !== 32'hE0) begin errors++; $display("FAIL blinker_back row10: got %h expected 000000e0", dut_grid[10]); end
        checks++; if (dut_grid[9] !== 32'h0 || dut_grid[11] !== 32'h0) begin
            errors++; $display("FAIL blinker_back rows9/11: got %h/%h expected 0/0", dut_grid[9], dut_grid[11]);
        end
    endtask

    task automatic test_glider;
        int nb;
        do_reset();
        for (int i = 0; i < 4; i++) run_step(nb);
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL glider row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
        checks++; if (dut_grid[1] !== 32'h4 || dut_grid[2] !== 32'h8 || dut_grid[3] !== 32'hE) begin
            errors++; $display("FAIL glider_shape: got %h %h %h expected 4 8 e", dut_grid[1], dut_grid[2], dut_grid[3]);
        end
        checks++; if (gen !== 16'd4) begin errors++; $display("FAIL glider_gen: got %0d expected 4", gen); end
    endtask

    task automatic test_wrap;
        int nb;
        logic [COLS-1:0] exp_edge;
`ifdef LIFE_TORUS_EN
        exp_edge = 32'h1;
`else
        exp_edge = 32'h0;
`endif
        do_reset();
        clear_grid();
        do_toggle(31, 0); do_toggle(0, 0); do_toggle(1, 0);
        run_step(nb);
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL wrap row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
        checks++; if (dut_grid[31] !== exp_edge || dut_grid[0] !== exp_edge || dut_grid[1] !== exp_edge) begin
            errors++; $display("FAIL wrap_edges: got %h %h %h expected %h", dut_grid[31], dut_grid[0], dut_grid[1], exp_edge);
        end
    endtask

    task automatic test_coalesce;
        int cnt, gap, quiet, g0;
        do_reset();
        for (int i = 0; i < 12; i++) do_toggle($urandom_range(3, 28), $urandom_range(3, 28));
        g0 = m_gen;
        step = 1'b1;
        tick();
        step = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            step = (cnt == 5 || cnt == 10 || cnt == 20);
            tick();
            step = 1'b0;
            cnt++;
        end
        gap = 0;
        while (busy !== 1'b1 && gap < 10) begin tick(); gap++; end
        checks++; if (gap != 1) begin errors++; $display("FAIL coalesce_restart: got %0d idle cycles expected 1", gap); end
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin cnt++; tick(); end
        checks++; if (cnt != 33) begin errors++; $display("FAIL coalesce_busy2: got %0d cycles expected 33", cnt); end
        quiet = 0;
        for (int i = 0; i < 60; i++) begin tick(); if (busy === 1'b1) quiet++; end
        checks++; if (quiet != 0) begin errors++; $display("FAIL coalesce_extra: got %0d busy cycles expected 0", quiet); end
        model_step();
        model_step();
        checks++; if (gen !== 16'(g0 + 2)) begin errors++; $display("FAIL coalesce_gen: got %0d expected %0d", gen, g0 + 2); end
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL coalesce row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
    endtask

    task automatic test_free_run;
        int changes, last_cyc, bad_iv;
        logic [15:0] prev;
        do_reset();
        changes = 0; last_cyc = -1; bad_iv = 0;
        prev = gen;
        run = 1'b1;
        for (int cyc = 1; cyc <= 240; cyc++) begin
            tick();
            if (cyc == 180) run = 1'b0;
            if (gen !== prev) begin
                changes++;
                if (last_cyc >= 0 && cyc - last_cyc != STEP_DIV) bad_iv++;
                last_cyc = cyc;
                prev = gen;
            end
        end
        for (int i = 0; i < 4; i++) model_step();
        checks++; if (changes != 4) begin errors++; $display("FAIL freerun_count: got %0d increments expected 4", changes); end
        checks++; if (bad_iv != 0) begin errors++; $display("FAIL freerun_period: got %0d bad intervals expected 0", bad_iv); end
        checks++; if (gen !== 16'(m_gen)) begin errors++; $display("FAIL freerun_gen: got %0d expected %0d", gen, m_gen); end
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL freerun row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
    endtask

    task automatic test_abort;
        int nb;
        do_reset();
        rdrow = '0;
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (15) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_midstep_busy: got %b expected 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (gen !== 16'd0) begin errors++; $display("FAIL abort_gen: got %0d expected 0", gen); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_rddata: got %h expected 0", rd); end
        tick();
        rst = 1'b0;
        model_seed();
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL abort_seed row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
        run_step(nb);
        checks++; if (nb != 33) begin errors++; $display("FAIL abort_step_busy: got %0d expected 33", nb); end
        checks++; if (gen !== 16'd1) begin errors++; $display("FAIL abort_step_gen: got %0d expected 1", gen); end
        read_grid();
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (dut_grid[r] !== m_grid[r]) begin
                errors++; $display("FAIL abort_gen1 row %0d: got %h expected %h", r, dut_grid[r], m_grid[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_glider();
        test_wrap();
        test_coalesce();
        test_free_run();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
